// File: rtl/multi_timer.sv
// Multi-channel programmable down-counter timer. All channels share one prescaler tick.
// Each channel has a runtime period, a one-shot or periodic mode, stop/restart control
// and a sticky interrupt flag.
module multi_timer #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          resetn_i,
  input  logic                          sync_resetn_i,
  input  logic                          enable_i,
  input  logic [PRESCALE_WIDTH-1:0]     prescale_i,
  input  logic [NUM_CH-1:0]             start_i,
  input  logic [NUM_CH-1:0]             stop_i,
  input  logic [NUM_CH-1:0]             mode_i,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   period_i,
  input  logic [NUM_CH-1:0]             irq_clr_i,
  output logic [NUM_CH-1:0]             done_o,
  output logic [NUM_CH-1:0]             irq_o,
  output logic [NUM_CH-1:0]             busy_o,
  output logic                          irq_any_o
);

  typedef enum logic {StIdle, StRun} state_e;

  logic [PRESCALE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic                      tick;

  state_e                    state_q  [NUM_CH];
  logic [CNT_WIDTH-1:0]      cnt_q    [NUM_CH];
  logic [CNT_WIDTH-1:0]      shadow_q [NUM_CH];
  logic [NUM_CH-1:0]         mode_q;
  logic [NUM_CH-1:0]         done_q;
  logic [NUM_CH-1:0]         irq_q, irq_d;
  logic                      irq_any_q;

  logic [NUM_CH-1:0]         start_ok;
  logic [NUM_CH-1:0]         expire;

  // Shared prescaler: >= compare so that lowering prescale mid-count still ticks promptly.
  always_comb begin
    tick      = enable_i && (pre_cnt_q >= prescale_i);
    pre_cnt_d = pre_cnt_q;
    if (enable_i) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    end
  end

  // Prescaler counter state.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      pre_cnt_q <= '0;
    end else if (!sync_resetn_i) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

  // Per-channel start qualification, expiry detection and sticky-flag next state.
  // Start and stop both take priority over expiry on the same edge.
  always_comb begin
    start_ok = '0;
    expire   = '0;
    busy_o   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      start_ok[i] = enable_i && start_i[i] && (period_i[i*CNT_WIDTH +: CNT_WIDTH] != '0);
      expire[i]   = tick && (state_q[i] == StRun) && !start_ok[i] && !stop_i[i] &&
                    (cnt_q[i] == CNT_WIDTH'(1));
      busy_o[i]   = (state_q[i] == StRun);
    end
    // Set wins over clear; clear acts regardless of enable.
    irq_d = (irq_q & ~irq_clr_i) | expire;
  end

  // Channel FSMs with registered done/irq outputs.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= StIdle;
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      mode_q    <= '0;
      done_q    <= '0;
      irq_q     <= '0;
      irq_any_q <= 1'b0;
    end else if (!sync_resetn_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= StIdle;
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      mode_q    <= '0;
      done_q    <= '0;
      irq_q     <= '0;
      irq_any_q <= 1'b0;
    end else begin
      done_q    <= expire;
      irq_q     <= irq_d;
      irq_any_q <= |irq_d;
      for (int i = 0; i < NUM_CH; i++) begin
        if (start_ok[i]) begin
          // Start from idle or restart mid-run; a tick on this edge is not counted.
          state_q[i]  <= StRun;
          cnt_q[i]    <= period_i[i*CNT_WIDTH +: CNT_WIDTH];
          shadow_q[i] <= period_i[i*CNT_WIDTH +: CNT_WIDTH];
          mode_q[i]   <= mode_i[i];
        end else if (enable_i && (state_q[i] == StRun)) begin
          if (stop_i[i]) begin
            state_q[i] <= StIdle;
            cnt_q[i]   <= '0;
          end else if (expire[i]) begin
            if (mode_q[i]) begin
              cnt_q[i] <= shadow_q[i];
            end else begin
              state_q[i] <= StIdle;
              cnt_q[i]   <= '0;
            end
          end else if (tick) begin
            cnt_q[i] <= cnt_q[i] - 1'b1;
          end
        end
      end
    end
  end

  assign done_o    = done_q;
  assign irq_o     = irq_q;
  assign irq_any_o = irq_any_q;

endmodule
